// File: rtl/ir_tx_scheduler_if.sv
// Intake bus of the shared IR frame encoder: 32-bit command with a valid/ready handshake.
interface ir_tx_scheduler_if;
  logic [31:0] enc_cmd;
  logic        enc_valid;
  logic        enc_ready;

  modport master (output enc_cmd, output enc_valid, input enc_ready);
  modport slave  (input enc_cmd, input enc_valid, output enc_ready);
endinterface

// File: rtl/ir_tx_scheduler.sv
// Round-robin arbiter that feeds one IR frame encoder from NUM_REQ command sources,
// acknowledging each frame on completion and aborting stalled frames with a watchdog.
module ir_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 8_000_000,
  parameter int TMO_W          = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*32-1:0] req_cmd_i,
  output logic [NUM_REQ-1:0]    ack_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic [ID_W-1:0]       grant_id_o,
  ir_tx_scheduler_if.master     enc
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_DONE      = 3'd3,
    S_ABORT     = 3'd4
  } state_t;

  localparam logic [TMO_W-1:0] WD_LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_REQ = ID_W'(NUM_REQ - 1);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [31:0]        cmd_q, cmd_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [TMO_W-1:0]   wd_q, wd_d, wd_inc_s;
  logic               found_s;
  logic [ID_W-1:0]    win_s;
  logic [31:0]        cmd_arr_s [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cmd
    assign cmd_arr_s[g] = req_cmd_i[32*g +: 32];
  end

  // Round-robin pick: first asserted request strictly after the last granted one.
  always_comb begin
    int   idx;
    logic hit;
    found_s = 1'b0;
    win_s   = ptr_q;
    idx     = 0;
    hit     = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx     = (int'(ptr_q) + k >= NUM_REQ) ? int'(ptr_q) + k - NUM_REQ : int'(ptr_q) + k;
      hit     = req_i[ID_W'(idx)] && !found_s;
      win_s   = hit ? ID_W'(idx) : win_s;
      found_s = found_s | hit;
    end
  end

  // Frame sequencing, watchdog and the values of every registered output.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    cmd_d      = cmd_q;
    wd_d       = wd_q;
    ack_d      = '0;
    // Saturate so a transfer landing on the limit still lets the wait phase time out.
    wd_inc_s   = (wd_q == WD_LIMIT) ? wd_q : wd_q + TMO_W'(1);
    case (state_q)
      S_IDLE: begin
        if (enable_i && found_s) begin
          state_d    = S_ISSUE;
          ptr_d      = win_s;
          grant_id_d = win_s;
          cmd_d      = cmd_arr_s[win_s];
          wd_d       = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        wd_d = wd_inc_s;
        if (enc.enc_ready) begin
          state_d = S_WAIT_DONE;
        end else if (wd_q == WD_LIMIT) begin
          state_d = S_ABORT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT_DONE: begin
        wd_d = wd_inc_s;
        if (enc.enc_ready) begin
          state_d = S_DONE;
        end else if (wd_q == WD_LIMIT) begin
          state_d = S_ABORT;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    valid_d = (state_d == S_ISSUE);
    busy_d  = (state_d != S_IDLE);
    err_d   = (state_d == S_ABORT);
    if ((state_d == S_DONE) || (state_d == S_ABORT)) begin
      ack_d[grant_id_d] = 1'b1;
    end else begin
      ack_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= LAST_REQ;
      grant_id_q <= LAST_REQ;
      cmd_q      <= 32'h0000_0000;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      ack_q      <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      cmd_q      <= cmd_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      ack_q      <= ack_d;
      wd_q       <= wd_d;
    end
  end

  assign ack_o         = ack_q;
  assign err_o         = err_q;
  assign busy_o        = busy_q;
  assign grant_id_o    = grant_id_q;
  assign enc.enc_cmd   = cmd_q;
  assign enc.enc_valid = valid_q;

endmodule

// File: tb/tb_ir_tx_scheduler.sv
// Directed bench for ir_tx_scheduler: frame-level reference model checked every cycle,
// an encoder model on the intake bus, and hand-computed grant orders and latencies.
module tb_ir_tx_scheduler;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TMO = 1000;
  localparam int TW  = 10;

  logic           clk     = 1'b0;
  logic           rst_n   = 1'b0;
  logic           enable  = 1'b0;
  logic [N-1:0]   req     = '0;
  logic [31:0]    tb_cmd [N];
  logic [N*32-1:0] req_cmd;
  logic [N-1:0]   ack;
  logic           err, busy;
  logic [IDW-1:0] gid;
  logic           enc_rdy = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit cmp_en    = 1'b0;
  bit auto_drop = 1'b1;

  ir_tx_scheduler_if enc_bus ();
  assign enc_bus.enc_ready = enc_rdy;
  assign req_cmd = {tb_cmd[3], tb_cmd[2], tb_cmd[1], tb_cmd[0]};

  ir_tx_scheduler #(.NUM_REQ(N), .ID_W(IDW), .TIMEOUT_CYCLES(TMO), .TMO_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .req_i(req), .req_cmd_i(req_cmd),
    .ack_o(ack), .err_o(err), .busy_o(busy), .grant_id_o(gid), .enc(enc_bus)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual '%s', required '%s'", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual no event in budget, required event (cycle %0d)", name, cyc);
  endtask

  function automatic string seq_str(input int q[$], input int from);
    string s = "";
    for (int i = from; i < q.size(); i++) s = {s, $sformatf("%0d", q[i])};
    return s;
  endfunction

  // Requesters drop their request once they see their own ack.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (auto_drop) req = req & ~ack;
    end
  endtask

  task automatic wait_ack(input int budget, output int at, output bit got);
    got = 1'b0;
    at  = 0;
    for (int k = 0; k < budget && !got; k++) begin
      tick(1);
      if (ack != '0) begin got = 1'b1; at = cyc; end
    end
    if (!got) fail_timeout("wait_ack");
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      tick(1);
      if (req == '0 && !busy) done = 1'b1;
    end
    if (!done) fail_timeout("wait_idle");
  endtask

  task automatic do_reset();
    req = '0;
    #5 rst_n = 1'b0;
    tick(2);
    #5 rst_n = 1'b1;
    tick(1);
  endtask

  // Encoder model: accepts after acc_dly valid cycles, then holds ready low hold_len cycles.
  int acc_dly = 3, hold_len = 50, enc_mode = 0, hold = 0, vcnt = 0, xfers = 0, rdy_rise_cyc = 0;
  bit xfer_q = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) xfer_q <= 1'b0;
    else begin
      xfer_q <= enc_bus.enc_valid && enc_rdy;
      if (enc_bus.enc_valid && enc_rdy) xfers <= xfers + 1;
    end
  end

  // mode 0: normal, 1: never finishes a frame, 2: never accepts
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_rdy = 1'b0; hold = 0; vcnt = 0;
    end else if (xfer_q) begin
      enc_rdy = 1'b0; hold = hold_len;
    end else if (hold > 0) begin
      hold = hold - 1;
      if (hold == 0 && enc_mode == 0) begin enc_rdy = 1'b1; rdy_rise_cyc = cyc; end
    end else if (!enc_rdy && enc_mode != 2 && enc_bus.enc_valid) begin
      vcnt++;
      if (vcnt >= acc_dly) begin enc_rdy = 1'b1; vcnt = 0; end
    end
  end

  // Reference model: one frame at a time, tracked by owner, age since grant and transfer flag.
  logic [N-1:0]   m_ack;
  logic           m_err, m_busy, m_valid;
  logic [IDW-1:0] m_gid;
  logic [31:0]    m_cmd;
  bit             m_active, m_tail, m_sent;
  int             m_owner, m_last, m_age;
  int             m_grants[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ack = '0; m_err = 1'b0; m_busy = 1'b0; m_valid = 1'b0;
      m_gid = IDW'(N - 1); m_cmd = 32'h0;
      m_active = 1'b0; m_tail = 1'b0; m_sent = 1'b0;
      m_owner = 0; m_last = N - 1; m_age = 0;
    end else begin
      m_ack = '0;
      m_err = 1'b0;
      if (m_tail) begin
        m_tail = 1'b0;
        m_busy = 1'b0;
      end else if (!m_active) begin
        if (enable && req != '0) begin
          int w;
          w = -1;
          for (int j = 1; j <= N; j++) begin
            int k;
            k = (m_last + j) % N;
            if (w < 0 && req[IDW'(k)]) w = k;
          end
          m_active = 1'b1; m_owner = w; m_last = w; m_age = 0; m_sent = 1'b0;
          m_cmd = tb_cmd[IDW'(w)]; m_gid = IDW'(w); m_valid = 1'b1; m_busy = 1'b1;
          m_grants.push_back(w);
        end
      end else begin
        m_age++;
        if (!m_sent && enc_rdy) begin
          m_sent = 1'b1; m_valid = 1'b0;
        end else if (m_sent && enc_rdy) begin
          m_active = 1'b0; m_tail = 1'b1; m_ack[IDW'(m_owner)] = 1'b1;
        end else if (m_age >= TMO) begin
          m_active = 1'b0; m_tail = 1'b1; m_valid = 1'b0;
          m_ack[IDW'(m_owner)] = 1'b1; m_err = 1'b1;
        end
      end
    end
  end

  int d_grants[$];
  bit prev_v = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ack",       64'(ack),               64'(m_ack));
      chk("err",       64'(err),               64'(m_err));
      chk("busy",      64'(busy),              64'(m_busy));
      chk("grant_id",  64'(gid),               64'(m_gid));
      chk("enc_valid", 64'(enc_bus.enc_valid), 64'(m_valid));
      chk("enc_cmd",   64'(enc_bus.enc_cmd),   64'(m_cmd));
      if (enc_bus.enc_valid && !prev_v) d_grants.push_back(int'(gid));
    end
    prev_v = enc_bus.enc_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual still running, required finish");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    int t_ack, t_grant, b, mb, x0, cnt;
    bit got;
    tb_cmd[0] = 32'h00FF_A55A;
    tb_cmd[1] = 32'h1111_2222;
    tb_cmd[2] = 32'h3333_4444;
    tb_cmd[3] = 32'h5555_6666;

    tick(3);
    chk("rst_ack",   64'(ack),               64'd0);
    chk("rst_err",   64'(err),               64'd0);
    chk("rst_busy",  64'(busy),              64'd0);
    chk("rst_gid",   64'(gid),               64'd3);
    chk("rst_valid", 64'(enc_bus.enc_valid), 64'd0);
    chk("rst_cmd",   64'(enc_bus.enc_cmd),   64'd0);
    #5 rst_n = 1'b1;
    cmp_en = 1'b1;
    tick(2);

    // Single request
    req = 4'b0001; enable = 1'b1;
    tick(1);
    chk("single_valid", 64'(enc_bus.enc_valid), 64'd1);
    chk("single_cmd",   64'(enc_bus.enc_cmd),   64'h00FF_A55A);
    chk("single_gid",   64'(gid),               64'd0);
    wait_ack(200, t_ack, got);
    if (got) begin
      chk("single_ack",     64'(ack),                  64'b0001);
      chk("single_err",     64'(err),                  64'd0);
      chk("single_ack_lat", 64'(t_ack - rdy_rise_cyc), 64'd1);
    end
    tick(1);
    chk("single_ack_width", 64'(ack),  64'd0);
    chk("single_busy_off",  64'(busy), 64'd0);

    // Contention
    do_reset();
    hold_len = 10;
    b = d_grants.size(); mb = m_grants.size();
    req = 4'b1111;
    wait_idle(2000);
    chk_s("cont_order",       seq_str(d_grants, b),  "0123");
    chk_s("model_cont_order", seq_str(m_grants, mb), "0123");
    b = d_grants.size(); mb = m_grants.size();
    req = 4'b1001;
    wait_idle(1000);
    chk_s("wrap_order",       seq_str(d_grants, b),  "03");
    chk_s("model_wrap_order", seq_str(m_grants, mb), "03");

    // Fairness with two requesters that never drop
    do_reset();
    auto_drop = 1'b0;
    b = d_grants.size(); mb = m_grants.size();
    req = 4'b0101;
    cnt = 0;
    for (int k = 0; k < 1500 && cnt < 6; k++) begin
      tick(1);
      if (ack != '0) cnt++;
    end
    req = '0;
    auto_drop = 1'b1;
    chk("fair_frames", 64'(cnt), 64'd6);
    wait_idle(200);
    chk_s("fair_order",       seq_str(d_grants, b),  "020202");
    chk_s("model_fair_order", seq_str(m_grants, mb), "020202");

    // Watchdog: encoder never finishes the frame
    do_reset();
    enc_mode = 1;
    req = 4'b0001;
    tick(1);
    t_grant = cyc;
    chk("wd_valid", 64'(enc_bus.enc_valid), 64'd1);
    wait_ack(1200, t_ack, got);
    if (got) begin
      chk("wd_ack",     64'(ack),             64'b0001);
      chk("wd_err",     64'(err),             64'd1);
      chk("wd_latency", 64'(t_ack - t_grant), 64'd1000);
    end
    enc_mode = 0;
    tick(1);
    req = 4'b0010;
    wait_ack(200, t_ack, got);
    if (got) begin
      chk("wd_next_ack", 64'(ack), 64'b0010);
      chk("wd_next_err", 64'(err), 64'd0);
    end

    // Stuck intake: ready never rises
    do_reset();
    enc_mode = 2;
    x0 = xfers;
    req = 4'b0001;
    cnt = 0;
    got = 1'b0;
    for (int k = 0; k < 1200 && !got; k++) begin
      tick(1);
      if (enc_bus.enc_valid) cnt++;
      if (ack != '0) begin
        got = 1'b1;
        chk("stuck_ack", 64'(ack), 64'b0001);
        chk("stuck_err", 64'(err), 64'd1);
      end
    end
    if (!got) fail_timeout("stuck_ack");
    chk("stuck_valid_cycles", 64'(cnt),        64'd1000);
    chk("stuck_no_xfer",      64'(xfers - x0), 64'd0);
    tick(1);
    chk("stuck_valid_low", 64'(enc_bus.enc_valid), 64'd0);
    enc_mode = 0;

    // Reset during WAIT_DONE, then enable gating
    do_reset();
    hold_len = 50;
    x0 = xfers;
    req = 4'b0100;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      tick(1);
      if (xfers > x0) got = 1'b1;
    end
    if (!got) fail_timeout("mid_xfer");
    tick(5);
    #5 rst_n = 1'b0;
    #1;
    chk("mid_rst_ack",   64'(ack),               64'd0);
    chk("mid_rst_err",   64'(err),               64'd0);
    chk("mid_rst_busy",  64'(busy),              64'd0);
    chk("mid_rst_gid",   64'(gid),               64'd3);
    chk("mid_rst_valid", 64'(enc_bus.enc_valid), 64'd0);
    chk("mid_rst_cmd",   64'(enc_bus.enc_cmd),   64'd0);
    cnt = 0;
    for (int k = 0; k < 2; k++) begin
      tick(1);
      if (ack != '0 || err) cnt++;
    end
    chk("mid_rst_no_ack", 64'(cnt), 64'd0);
    #5 rst_n = 1'b1;
    enable = 1'b0;
    req = 4'b0010;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      if (enc_bus.enc_valid || busy) cnt++;
    end
    chk("en0_no_grant", 64'(cnt), 64'd0);
    enable = 1'b1;
    tick(1);
    chk("en1_valid", 64'(enc_bus.enc_valid), 64'd1);
    chk("en1_cmd",   64'(enc_bus.enc_cmd),   64'h1111_2222);
    chk("en1_gid",   64'(gid),               64'd1);
    wait_ack(200, t_ack, got);
    if (got) chk("en1_ack", 64'(ack), 64'b0010);
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_tx_scheduler.md
Name: ir_tx_scheduler

Overview:
Round-robin scheduler that shares one IR frame encoder (32-bit command, valid/ready intake, ready held low for the whole frame and inter-frame gap) between NUM_REQ command sources such as keypad, UART bridge and auto-repeat logic. It grants one requester at a time and drives the encoder intake with that requester's command. It detects frame completion when the encoder ready rises again, acknowledges the requester, and recovers from a stalled encoder with a watchdog.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of grant_id; must satisfy 2**ID_W >= NUM_REQ
TIMEOUT_CYCLES, 8_000_000, watchdog limit in clk cycles from grant to completion (320 ms at 25 MHz; covers start pulse + 32 bits + 200 ms gap)
TMO_W, 24, watchdog counter width; must hold TIMEOUT_CYCLES-1

Ports:
clk  in  1  system clock, 25 MHz
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = new grants allowed; 0 = finish in-flight frame, grant nothing new
req  in  NUM_REQ  per-requester request level; held high until own ack
req_cmd  in  NUM_REQ*32  packed commands, requester i at bits [32*i+31:32*i]
ack  out  NUM_REQ  one-hot 1-cycle pulse: requester's frame finished (or aborted)
err  out  1  1-cycle pulse coincident with ack on watchdog abort
busy  out  1  high in every state except IDLE
grant_id  out  ID_W  index of current/last granted requester
enc_cmd  out  32  command to encoder
enc_valid  out  1  encoder intake valid
enc_ready  in  1  encoder ready

Behaviour:
- One clock domain. Async reset asserts immediately and releases synchronously to clk. All outputs are registered.
- Reset values: ack=0, err=0, busy=0, grant_id=NUM_REQ-1, enc_cmd=0, enc_valid=0, state=IDLE, last-grant pointer=NUM_REQ-1 (requester 0 wins first), watchdog=0.
- States: IDLE, ISSUE, WAIT_DONE, DONE, ABORT.
- IDLE: if enable=1 and req!=0, select the first set req scanning from pointer+1 upward, modulo NUM_REQ.
  - On that edge: enc_cmd<=winner's cmd; grant_id<=winner; pointer<=winner; enc_valid<=1; watchdog<=0; go ISSUE.
  - Latency: enc_valid is high one cycle after req is sampled.
- ISSUE: enc_valid=1 and enc_cmd stable. Watchdog increments each cycle.
  - An edge with enc_ready=1 is the transfer: enc_valid<=0, go WAIT_DONE.
- WAIT_DONE: watchdog keeps incrementing.
  - The first cycle after transfer sees enc_ready=0 (the encoder clears ready on the accept edge).
  - Completion is the first edge with enc_ready=1: go DONE.
- DONE: exactly one cycle; ack[grant_id]=1, busy=1; then IDLE.
  - Requesters drop req on the edge where they sample ack=1, so the next IDLE cycle arbitrates without the finished requester.
- Watchdog: in ISSUE or WAIT_DONE, an edge where the watchdog equals TIMEOUT_CYCLES-1 and no transfer/completion is seen goes to ABORT with enc_valid<=0.
  - Completion on the same edge as the limit wins (go DONE, no err).
- ABORT: exactly one cycle; ack[grant_id]=1 and err=1; then IDLE. Pointer is already advanced, so the aborting requester does not monopolise.
- Requester rules:
  - A req deasserted after grant does not cancel the frame; the command is still sent and ack still pulses.
  - req_cmd changes after grant have no effect.
- enable=0 mid-frame does not affect ISSUE/WAIT_DONE/DONE/ABORT; it only blocks the IDLE grant.
- Simultaneous requests: exactly one grant per frame; fairness is strict round-robin; no requester waits more than NUM_REQ-1 frames.
- Reset mid-frame: return to reset values immediately; no ack or err is emitted; the encoder is reset by its own reset.
- Invariants: at most one ack bit set; enc_valid=1 only in ISSUE; err=1 only together with ack.

Test Plan:
- Single request: req=0001, cmd0=0x00FF_A55A, encoder model accepts after 3 cycles and holds ready low 50 cycles -> enc_cmd=0x00FF_A55A while enc_valid=1; ack=0001 for one cycle 1 cycle after enc_ready rises; busy low the following cycle.
- Contention: req=1111 held, each requester drops after its ack -> grant order 0,1,2,3; then re-raise req=1001 -> order 0,3 (pointer continues from 3 wraps to 0).
- Fairness: req0 and req2 permanently re-raised -> grants alternate 0,2,0,2 over 6 frames; requester 1 never granted.
- Watchdog: TIMEOUT_CYCLES=1000, encoder ready held 0 after accept -> ack and err pulse together 1000 cycles after grant; next request granted normally.
- Stuck intake: enc_ready held 0 from the start -> enc_valid high exactly 1000 cycles then low; err=1; no transfer recorded.
- Reset and enable: rst_n low during WAIT_DONE -> all outputs at reset values and no ack. With enable=0 and req=0010 -> no grant for 100 cycles; enable=1 -> enc_valid next cycle with cmd1.
